// File: rtl/mul_div_pkg.sv
// mul_div_pkg: shared encodings, state type and default width for the mul/div unit
package mul_div_pkg;
  localparam int WIDTH = 32;
  localparam int DIV_BITS_PER_CYCLE = 2;
  localparam logic [3:0] OP_DIV   = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MUL   = 4'b0010;
  localparam logic [3:0] OP_MULTU = 4'b0001;
  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;
endpackage

// File: rtl/mul_div_div_core.sv
// div_core_u: unsigned iterative restoring divider resolving BITS quotient bits per cycle
module div_core_u #(
  parameter int WIDTH = 32,
  parameter int BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);
  localparam int ITERS = WIDTH / BITS;
  localparam int CW = $clog2(ITERS + 1);
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] d, nq, nr;
  logic [WIDTH:0] t;
  logic ge;
  // quo doubles as the dividend shift register; quotient bits enter from the bottom
  always_comb begin
    nq = quo;
    nr = rem;
    t = '0;
    ge = 1'b0;
    for (int i = 0; i < BITS; i++) begin
      t = {nr, nq[WIDTH-1]};
      ge = t >= {1'b0, d};
      nq = {nq[WIDTH-2:0], ge};
      nr = ge ? WIDTH'(t - {1'b0, d}) : t[WIDTH-1:0];
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      quo <= '0;
      rem <= '0;
      d <= '0;
    end else if (start) begin
      cnt <= CW'(ITERS);
      quo <= dividend;
      rem <= '0;
      d <= divisor;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      quo <= nq;
      rem <= nr;
    end
  end
  assign busy = cnt != '0;
  assign done = cnt == CW'(1);
endmodule

// File: rtl/mul_div.sv
// mul_div: multi-cycle MULT/MULTU/DIV/DIVU unit; q = LO/quotient, r = HI/remainder
module mul_div #(
  parameter int WIDTH = mul_div_pkg::WIDTH,
  parameter int DIV_BITS_PER_CYCLE = mul_div_pkg::DIV_BITS_PER_CYCLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       choice,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             buzy,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);
  import mul_div_pkg::*;
  state_t state;
  logic [3:0] op;
  logic [WIDTH-1:0] ra, rb, quo, rem, abs_a, abs_b, dq, dr;
  logic [2*WIDTH-1:0] prod, ea, eb;
  logic [4+2*WIDTH-1:0] last;
  logic launch, is_div, sdiv, smul, is_mul, neg_q, neg_r, core_busy, core_done;
  assign launch = state == IDLE && $onehot(choice) && {choice, a, b} != last;
  assign is_div = choice == OP_DIV || choice == OP_DIVU;
  assign sdiv = choice == OP_DIV;
  assign abs_a = sdiv && a[WIDTH-1] ? -a : a;
  assign abs_b = sdiv && b[WIDTH-1] ? -b : b;
  assign smul = op == OP_MUL;
  assign is_mul = op == OP_MUL || op == OP_MULTU;
  assign ea = {{WIDTH{smul & ra[WIDTH-1]}}, ra};
  assign eb = {{WIDTH{smul & rb[WIDTH-1]}}, rb};
  assign dq = neg_q ? -quo : quo;
  assign dr = neg_r ? -rem : rem;
  div_core_u #(.WIDTH(WIDTH), .BITS(DIV_BITS_PER_CYCLE)) u_div (
    .clk(clk), .rst(rst), .start(launch && is_div), .dividend(abs_a), .divisor(abs_b),
    .busy(core_busy), .done(core_done), .quo(quo), .rem(rem)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      buzy <= 1'b0;
      q <= '0;
      r <= '0;
      op <= '0;
      ra <= '0;
      rb <= '0;
      prod <= '0;
      last <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (launch) begin
          op <= choice;
          ra <= a;
          rb <= b;
          last <= {choice, a, b};
          // a zero divisor keeps the all-ones quotient unsigned-looking
          neg_q <= sdiv && (a[WIDTH-1] ^ b[WIDTH-1]) && b != '0;
          neg_r <= sdiv && a[WIDTH-1];
          buzy <= 1'b1;
          state <= is_div ? DIV_RUN : MUL_RUN;
        end
        MUL_RUN: begin
          prod <= ea * eb;
          state <= DONE;
        end
        DIV_RUN: if (core_done || !core_busy) state <= DONE;
        DONE: begin
          q <= is_mul ? prod[WIDTH-1:0] : dq;
          r <= is_mul ? prod[2*WIDTH-1:WIDTH] : dr;
          buzy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div.sv
// tb_mul_div: directed vectors checked against a cycle-level arithmetic model plus literal results
module tb_mul_div;
  import mul_div_pkg::*;
  logic clk = 0, rst = 1, buzy;
  logic [3:0] choice = 0;
  logic [31:0] a = 0, b = 0, q, r;
  int n_cmp = 0, n_bad = 0;
  bit chk = 0;
  logic m_busy = 0;
  logic [31:0] m_q = 0, m_r = 0, p_q = 0, p_r = 0;
  logic [67:0] m_last = 0;
  int m_cnt = 0;

  mul_div dut (.clk(clk), .rst(rst), .choice(choice), .a(a), .b(b), .buzy(buzy), .q(q), .r(r));

  always #5 clk = ~clk;

  function automatic logic [63:0] golden(logic [3:0] c, logic [31:0] x, logic [31:0] y);
    longint sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    if (c == OP_MUL) return 64'(sx * sy);
    if (c == OP_MULTU) return {32'b0, x} * {32'b0, y};
    if (y == 0) return {x, 32'hFFFF_FFFF};
    if (c == OP_DIV) return {32'(sx % sy), 32'(sx / sy)};
    return {x % y, x / y};
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_busy = 0; m_q = 0; m_r = 0; m_cnt = 0; m_last = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 0;
        m_q = p_q;
        m_r = p_r;
      end
    end else if ($onehot(choice) && {choice, a, b} != m_last) begin
      m_last = {choice, a, b};
      {p_r, p_q} = golden(choice, a, b);
      m_cnt = (choice == OP_MUL || choice == OP_MULTU) ? 2 : 17;
      m_busy = 1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk) begin
      n_cmp++;
      if ({buzy, q, r} !== {m_busy, m_q, m_r}) begin
        n_bad++;
        $display("FAIL cycle t=%0t dut buzy=%b q=%h r=%h model buzy=%b q=%h r=%h",
                 $time, buzy, q, r, m_busy, m_q, m_r);
      end
    end
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic wait_done(string nm, logic [31:0] eq, logic [31:0] er, int lat);
    int n = 0;
    @(negedge clk);
    while (buzy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({nm, "_latency"}, 32'(n), 32'(lat));
    check({nm, "_q"}, q, eq);
    check({nm, "_r"}, r, er);
    check({nm, "_model_q"}, m_q, eq);
    check({nm, "_model_r"}, m_r, er);
  endtask

  task automatic run(string nm, logic [3:0] c, logic [31:0] x, logic [31:0] y,
                     logic [31:0] eq, logic [31:0] er, int lat);
    @(negedge clk);
    choice = c; a = x; b = y;
    wait_done(nm, eq, er, lat);
  endtask

  initial begin
    #1 rst = 0;
    repeat (3) @(negedge clk);
    check("rst_buzy", 32'(buzy), 0);
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    rst = 1;
    chk = 1;
    repeat (6) @(negedge clk);
    check("idle_buzy", 32'(buzy), 0);
    check("idle_q", q, 0);
    run("div_m4_2", OP_DIV, 32'hFFFF_FFFC, 2, 32'hFFFF_FFFE, 0, 17);
    run("divu_fffc_2", OP_DIVU, 32'hFFFF_FFFC, 2, 32'h7FFF_FFFE, 0, 17);
    run("divu_4_2", OP_DIVU, 4, 2, 2, 0, 17);
    repeat (5) @(negedge clk);
    check("no_relaunch_buzy", 32'(buzy), 0);
    run("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 17);
    run("divu_7_0", OP_DIVU, 7, 0, 32'hFFFF_FFFF, 7, 17);
    run("div_m5_0", OP_DIV, 32'hFFFF_FFFB, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 17);
    run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 17);
    run("div_100_m7", OP_DIV, 100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 2, 17);
    run("mul_m4_2", OP_MUL, 32'hFFFF_FFFC, 2, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 2);
    run("mul_7_f", OP_MUL, 7, 32'hF, 32'h69, 0, 2);
    run("multu_fffc_2", OP_MULTU, 32'hFFFF_FFFC, 2, 32'hFFFF_FFF8, 1, 2);
    run("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 2);
    @(negedge clk);
    choice = 4'b0011; a = 9; b = 3;
    repeat (4) @(negedge clk);
    check("nonhot_buzy", 32'(buzy), 0);
    check("nonhot_q", q, 1);
    choice = OP_DIV; a = 100; b = 7;
    repeat (6) @(negedge clk);
    check("mid_buzy", 32'(buzy), 1);
    #2 rst = 0;
    #1;
    check("abort_buzy", 32'(buzy), 0);
    check("abort_q", q, 0);
    check("abort_r", r, 0);
    @(negedge clk);
    rst = 1;
    wait_done("relaunch", 14, 2, 17);
    repeat (3) @(negedge clk);
    chk = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
